glitcbus_slave: RTL and testbench
=================================

Name: glitcbus_slave

Overview:
- Byte-wide GLITCBUS slave front end, clocked by the deskewed GLITCBUS clock gb_clk.
- Decodes master read/write transactions on the 8-bit shared bus: one address byte, then 4 data bytes.
- Presents single-cycle register-file strobes (address, 32-bit data) to the downstream register block.
- Returns read data to the master.

Parameters:
- ADDR_BITS, 7: register address width taken from the address byte (1..8).
- ACK_TIMEOUT, 15: cycles to wait for ack_i after rd_o before aborting the read (1..255).

Ports:
- gb_clk_i  input  1  GLITCBUS clock; sole clock.
- gb_rst_i  input  1  asynchronous, active-high reset.
- gsel_b_i  input  1  bus select, active low; frames a transaction.
- grdwr_b_i  input  1  direction, sampled with the address byte: 1=read, 0=write.
- gad_i  input  8  bus address/data in.
- gad_o  output  8  bus data out (read data).
- gad_oe_o  output  1  bus output enable for gad_o.
- gready_o  output  1  slave ready/done indication to master.
- addr_o  output  ADDR_BITS  register address.
- dat_o  output  32  write data.
- wr_o  output  1  write strobe, 1 cycle.
- rd_o  output  1  read strobe, 1 cycle.
- dat_i  input  32  read data from register block.
- ack_i  input  1  read data valid.
- timeout_o  output  1  1-cycle pulse on read timeout.

Behaviour:
- Clock and reset:
  - Single clock gb_clk_i.
  - Reset gb_rst_i is asynchronous and active-high.
  - Reset forces state IDLE, all outputs 0, input registers to idle (gsel_q=1).
- Input registering:
  - gsel_b_i, grdwr_b_i, gad_i are registered every edge into gsel_q, rw_q, gad_q (IOB-packable, no reset dependence other than gsel_q).
  - The FSM acts only on the registered copies.
- Bus framing (master side):
  - Bus cycle A: gsel_b low, gad = address byte.
  - Write: bus cycles A+1..A+4 carry data bytes 0..3, LSB first.
  - The master holds gsel_b low until it sees gready, then releases it.
- State IDLE:
  - On gsel_q==0, latch addr_o <= gad_q[ADDR_BITS-1:0] and direction <= rw_q.
  - Go to WDATA (write) or RREQ (read); clear byte counter.
- State WDATA:
  - Each cycle, shift gad_q into dat_o[8k+7:8k], k = 0..3.
  - After k=3, go to WCOMMIT.
- State WCOMMIT:
  - wr_o=1 for exactly one cycle with addr_o/dat_o stable.
  - gready_o<=1; go to DONE.
- State RREQ:
  - rd_o=1 on the first cycle only.
  - Then wait for ack_i, incrementing a timeout counter.
  - ack_i seen (including in the rd_o cycle): latch dat_i, go to RDATA.
  - Counter reaches ACK_TIMEOUT without ack_i: latch 32'hFFFFFFFF, pulse timeout_o, go to RDATA.
- State RDATA:
  - gad_oe_o=1, gad_o = byte k of the latched word, k = 0..3, one per cycle.
  - gready_o<=1 from the first byte onward.
  - After k=3, gad_oe_o<=0 and go to DONE.
- State DONE:
  - Hold gready_o=1 until gsel_q==1, then gready_o<=0 and go to IDLE.
  - IDLE then requires a fresh gsel_q low; no back-to-back without deselect.
- Abort:
  - gsel_q==1 in WDATA, RREQ or RDATA: go to IDLE immediately.
  - On abort: gad_oe_o<=0, gready_o<=0, no wr_o; no further rd_o beyond one already issued.
- Simultaneous events: in WDATA, abort takes priority over completing byte 3 (no wr_o).
- ack_i outside RREQ is ignored.
- addr_o holds its last value between transactions. dat_o holds the last write data.
- Latency: wr_o is asserted 6 edges after the edge that first samples gsel_b_i low.
- Reset mid-transaction: immediate IDLE, gad_oe_o drops asynchronously, no strobes afterwards.

Test Plan:
- Write addr 0x05, bytes 0x78,0x56,0x34,0x12 -> exactly one wr_o pulse, addr_o=0x05, dat_o=0x12345678, 6 edges after first gsel_q low. gready_o stays 1 until gsel_b released, then 0 next cycle.
- Read addr 0x7F, ack_i 2 cycles after rd_o with dat_i=0xCAFEBABE -> one rd_o pulse; gad_o sequence 0xBE,0xBA,0xFE,0xCA with gad_oe_o=1 for exactly 4 cycles; gready_o high.
- Read with ack_i never asserted, ACK_TIMEOUT=15 -> timeout_o one pulse 15 cycles after rd_o; gad_o returns 0xFF ×4.
- Write aborted by gsel_b high after data byte 2 -> no wr_o; state IDLE; gready_o stays 0. A following valid write completes normally.
- Assert gb_rst_i asynchronously during RDATA byte 1 -> gad_oe_o, gready_o, rd_o, wr_o go 0 without a clock edge. After release, a new read transaction works.
- ADDR_BITS=4, address byte 0xA3 -> addr_o=0x3. ack_i pulses while IDLE -> no effect.

Source files
------------

// File: rtl/glitcbus_slave.sv
`default_nettype none
// ============================================================================
// Module   : glitcbus_slave
// Purpose  : Byte-wide GLITCBUS slave front end. It turns framed bus reads and
//            writes into single-cycle register strobes and returns read data.
// Revision : 1.0 - initial release
// ============================================================================
module glitcbus_slave #(
  parameter int ADDR_BITS   = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 gb_clk_i,
  input  logic                 gb_rst_i,
  input  logic                 gsel_b_i,
  input  logic                 grdwr_b_i,
  input  logic [7:0]           gad_i,
  output logic [7:0]           gad_o,
  output logic                 gad_oe_o,
  output logic                 gready_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [31:0]          dat_o,
  output logic                 wr_o,
  output logic                 rd_o,
  input  logic [31:0]          dat_i,
  input  logic                 ack_i,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WDATA   = 3'd1,
    S_WCOMMIT = 3'd2,
    S_RREQ    = 3'd3,
    S_RDATA   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] c_tmo_last = 8'(ACK_TIMEOUT - 1);

  logic                 r_gsel_q;
  logic                 r_rw_q;
  logic [7:0]           r_gad_q;

  state_t               r_state,  w_state_nxt;
  logic [1:0]           r_byte,   w_byte_nxt;
  logic [7:0]           r_tmo,    w_tmo_nxt;
  logic [ADDR_BITS-1:0] r_addr,   w_addr_nxt;
  logic [31:0]          r_dat,    w_dat_nxt;
  logic [31:0]          r_shift,  w_shift_nxt;
  logic                 r_wr,     w_wr_nxt;
  logic                 r_rd,     w_rd_nxt;
  logic                 r_to,     w_to_nxt;
  logic                 r_gready, w_gready_nxt;
  logic                 r_oe,     w_oe_nxt;

  // Bus inputs: only the select needs a reset value so the FSM sees an idle bus.
  always_ff @(posedge gb_clk_i or posedge gb_rst_i) begin
    if (gb_rst_i) r_gsel_q <= 1'b1;
    else          r_gsel_q <= gsel_b_i;
  end

  always_ff @(posedge gb_clk_i) begin
    r_rw_q  <= grdwr_b_i;
    r_gad_q <= gad_i;
  end

  always_ff @(posedge gb_clk_i or posedge gb_rst_i) begin
    if (gb_rst_i) begin
      r_state  <= S_IDLE;
      r_byte   <= '0;
      r_tmo    <= '0;
      r_addr   <= '0;
      r_dat    <= '0;
      r_shift  <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_to     <= 1'b0;
      r_gready <= 1'b0;
      r_oe     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_byte   <= w_byte_nxt;
      r_tmo    <= w_tmo_nxt;
      r_addr   <= w_addr_nxt;
      r_dat    <= w_dat_nxt;
      r_shift  <= w_shift_nxt;
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_to     <= w_to_nxt;
      r_gready <= w_gready_nxt;
      r_oe     <= w_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_nxt   = r_byte;
    w_tmo_nxt    = r_tmo;
    w_addr_nxt   = r_addr;
    w_dat_nxt    = r_dat;
    w_shift_nxt  = r_shift;
    w_wr_nxt     = 1'b0;
    w_rd_nxt     = 1'b0;
    w_to_nxt     = 1'b0;
    w_gready_nxt = r_gready;
    w_oe_nxt     = r_oe;

    case (r_state)
      S_IDLE: begin
        w_gready_nxt = 1'b0;
        w_oe_nxt     = 1'b0;
        if (!r_gsel_q) begin
          w_addr_nxt = r_gad_q[ADDR_BITS-1:0];
          w_byte_nxt = '0;
          w_tmo_nxt  = '0;
          if (r_rw_q) begin
            w_state_nxt = S_RREQ;
            w_rd_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_WDATA;
          end
        end
      end

      // Bytes arrive LSB first, so shifting in from the top lands byte 0 at [7:0].
      S_WDATA: begin
        if (r_gsel_q) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dat_nxt  = {r_gad_q, r_dat[31:8]};
          w_byte_nxt = r_byte + 2'd1;
          if (r_byte == 2'd3) w_state_nxt = S_WCOMMIT;
        end
      end

      S_WCOMMIT: begin
        w_wr_nxt     = 1'b1;
        w_gready_nxt = 1'b1;
        w_state_nxt  = S_DONE;
      end

      S_RREQ: begin
        if (r_gsel_q) begin
          w_state_nxt  = S_IDLE;
          w_gready_nxt = 1'b0;
          w_oe_nxt     = 1'b0;
        end else if (ack_i) begin
          w_shift_nxt  = dat_i;
          w_byte_nxt   = '0;
          w_oe_nxt     = 1'b1;
          w_gready_nxt = 1'b1;
          w_state_nxt  = S_RDATA;
        end else if (r_tmo == c_tmo_last) begin
          w_shift_nxt  = 32'hFFFF_FFFF;
          w_to_nxt     = 1'b1;
          w_byte_nxt   = '0;
          w_oe_nxt     = 1'b1;
          w_gready_nxt = 1'b1;
          w_state_nxt  = S_RDATA;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end

      S_RDATA: begin
        if (r_gsel_q) begin
          w_state_nxt  = S_IDLE;
          w_gready_nxt = 1'b0;
          w_oe_nxt     = 1'b0;
        end else if (r_byte == 2'd3) begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = S_DONE;
        end else begin
          w_shift_nxt = {8'h00, r_shift[31:8]};
          w_byte_nxt  = r_byte + 2'd1;
        end
      end

      S_DONE: begin
        if (r_gsel_q) begin
          w_gready_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_gready_nxt = 1'b0;
        w_oe_nxt     = 1'b0;
      end
    endcase
  end

  assign gad_o     = r_oe ? r_shift[7:0] : 8'h00;
  assign gad_oe_o  = r_oe;
  assign gready_o  = r_gready;
  assign addr_o    = r_addr;
  assign dat_o     = r_dat;
  assign wr_o      = r_wr;
  assign rd_o      = r_rd;
  assign timeout_o = r_to;

endmodule
`default_nettype wire

// File: tb/tb_glitcbus_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitcbus_slave
// Purpose  : Directed bench for glitcbus_slave with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitcbus_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gsel_b = 1'b1;
  logic        grdwr_b = 1'b0;
  logic [7:0]  gad = 8'h00;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;

  logic [7:0]  gad_o, gad_o4;
  logic        gad_oe, gad_oe4, gready, gready4;
  logic [6:0]  addr;
  logic [3:0]  addr4;
  logic [31:0] dat_o, dat_o4;
  logic        wr, wr4, rd, rd4, tmo, tmo4;

  glitcbus_slave #(.ADDR_BITS(7), .ACK_TIMEOUT(15)) u_dut (
    .gb_clk_i(clk), .gb_rst_i(rst), .gsel_b_i(gsel_b), .grdwr_b_i(grdwr_b),
    .gad_i(gad), .gad_o(gad_o), .gad_oe_o(gad_oe), .gready_o(gready),
    .addr_o(addr), .dat_o(dat_o), .wr_o(wr), .rd_o(rd),
    .dat_i(dat_i), .ack_i(ack), .timeout_o(tmo)
  );

  glitcbus_slave #(.ADDR_BITS(4), .ACK_TIMEOUT(15)) u_dut4 (
    .gb_clk_i(clk), .gb_rst_i(rst), .gsel_b_i(gsel_b), .grdwr_b_i(grdwr_b),
    .gad_i(gad), .gad_o(gad_o4), .gad_oe_o(gad_oe4), .gready_o(gready4),
    .addr_o(addr4), .dat_o(dat_o4), .wr_o(wr4), .rd_o(rd4),
    .dat_i(dat_i), .ack_i(ack), .timeout_o(tmo4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cyc = 0;

  logic [38:0] wr_q[$];
  logic [6:0]  rd_q[$];
  logic [7:0]  byte_q[$];
  int          to_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop an expectation whenever the DUT presents an output event.
  always @(negedge clk) begin
    logic [38:0] e;
    int          lat;
    if (wr) begin
      if (wr_q.size() == 0) chk("unexpected_wr", wr, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", addr, e[38:32]);
        chk("wr_data", dat_o, e[31:0]);
      end
    end
    if (rd) begin
      rd_cyc = cyc;
      if (rd_q.size() == 0) chk("unexpected_rd", rd, 0);
      else chk("rd_addr", addr, rd_q.pop_front());
    end
    if (gad_oe) begin
      if (byte_q.size() == 0) chk("unexpected_oe", gad_oe, 0);
      else chk("rd_byte", gad_o, byte_q.pop_front());
    end
    if (tmo) begin
      if (to_q.size() == 0) chk("unexpected_timeout", tmo, 0);
      else begin
        lat = to_q.pop_front();
        chk("timeout_latency", cyc - rd_cyc, lat);
      end
    end
  end

  task automatic wait_gready(input int max_cyc);
    int n = 0;
    while (gready !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("gready_wait", gready, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int nbytes,
                          input logic [6:0] exp_addr);
    if (nbytes == 4) wr_q.push_back({exp_addr, d});
    @(negedge clk);
    gsel_b = 1'b0; grdwr_b = 1'b0; gad = a;
    @(posedge clk);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      gad = d[8*i +: 8];
    end
    if (nbytes < 4) begin
      @(negedge clk);
      gsel_b = 1'b1; gad = 8'h00;
      repeat (6) begin
        @(negedge clk);
        chk("abort_gready", gready, 0);
      end
    end else begin
      repeat (2) @(posedge clk);
      #1 chk("wr_early", wr, 0);
      @(posedge clk);
      #1 chk("wr_latency", wr, 1);
      chk("wr_gready", gready, 1);
      @(negedge clk);
      gsel_b = 1'b1; gad = 8'h00;
      @(posedge clk);
      #1 chk("gready_hold", gready, 1);
      @(posedge clk);
      #1 chk("gready_drop", gready, 0);
    end
  endtask

  // ack_dly < 0 means the register block never acknowledges.
  task automatic do_read(input logic [7:0] a, input int ack_dly, input logic [31:0] d);
    logic [31:0] w;
    w = (ack_dly < 0) ? 32'hFFFF_FFFF : d;
    rd_q.push_back(a[6:0]);
    for (int i = 0; i < 4; i++) byte_q.push_back(w[8*i +: 8]);
    if (ack_dly < 0) to_q.push_back(15);
    @(negedge clk);
    gsel_b = 1'b0; grdwr_b = 1'b1; gad = a;
    @(posedge clk);
    @(negedge clk);
    gad = 8'h00;
    if (ack_dly >= 0) begin
      @(posedge clk);
      repeat (ack_dly) @(posedge clk);
      @(negedge clk);
      ack = 1'b1; dat_i = d;
      @(negedge clk);
      ack = 1'b0; dat_i = 32'h0;
    end
    wait_gready(40);
    repeat (4) @(negedge clk);
    chk("oe_off_after_4", gad_oe, 0);
    gsel_b = 1'b1; grdwr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("read_gready_drop", gready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #23;
    chk("rst_gad_o", gad_o, 0);
    chk("rst_gad_oe", gad_oe, 0);
    chk("rst_gready", gready, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_wr_rd_to", {wr, rd, tmo}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_write(8'h05, 32'h1234_5678, 4, 7'h05);
    do_read(8'h7F, 2, 32'hCAFE_BABE);
    do_read(8'h11, -1, 32'h0);
    do_write(8'h22, 32'hDEAD_BEEF, 3, 7'h22);
    do_write(8'h33, 32'hA5A5_5A5A, 4, 7'h33);

    // Async reset while the second read byte is on the bus.
    rd_q.push_back(7'h55);
    byte_q.push_back(8'hEF);
    byte_q.push_back(8'hCD);
    @(negedge clk);
    gsel_b = 1'b0; grdwr_b = 1'b1; gad = 8'h55;
    @(posedge clk);
    @(negedge clk);
    gad = 8'h00;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b1; dat_i = 32'h89AB_CDEF;
    @(negedge clk);
    ack = 1'b0; dat_i = 32'h0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gad_oe", gad_oe, 0);
    chk("arst_gready", gready, 0);
    chk("arst_rd_wr", {rd, wr}, 0);
    chk("arst_gad_o", gad_o, 0);
    gsel_b = 1'b1; grdwr_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_read(8'h42, 0, 32'h0102_0304);
    do_write(8'hA3, 32'h0BAD_F00D, 4, 7'h23);
    chk("addr4_trunc", addr4, 4'h3);

    // ack pulses while idle must not provoke anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack = 1'b1; dat_i = 32'h5555_0000 + i;
      @(negedge clk);
      ack = 1'b0;
      chk("idle_ack_gready", gready, 0);
      chk("idle_ack_oe", gad_oe, 0);
    end
    repeat (3) @(negedge clk);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("byte_q_empty", byte_q.size(), 0);
    chk("to_q_empty", to_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
